ram_delay_pipe: RTL

- Parametrised memory-latency injector between a processor memory port (client side) and a synchronous RAM (memory side).
- Delays requests and read responses by separately runtime-configurable cycle counts, for modelling slow or remote memories in simulation and FPGA builds.
- Supports two modes:
  - blocking: one request outstanding, stall via client_delay.
  - pipelined: one request per cycle, in-order responses flagged by client_valid_r.

---
 rtl/ram_delay_pkg.sv | 16 +
 rtl/ram_delay_tapline.sv | 38 +++
 rtl/ram_delay_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ram_delay_pkg.sv
// Shared types and helpers for the RAM latency injector.
package ram_delay_pkg;

  typedef enum logic {
    MODE_BLOCKING  = 1'b0,
    MODE_PIPELINED = 1'b1
  } Ram_delay_mode;

  function automatic logic [31:0] sat_delay(input logic [31:0] value, input logic [31:0] max_value);
    logic [31:0] res;
    if (value > max_value) res = max_value;
    else res = value;
    return res;
  endfunction

endpackage

// File: rtl/ram_delay_tapline.sv
// Shift register with a runtime tap: tap 0 is the input itself, tap k the entry k cycles old.
module ram_delay_tapline #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int TW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TW-1:0]    tap_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] taps_s  [DEPTH+1];
  logic [TW-1:0]    sel_s;

  // Shift one entry per cycle; reset empties the whole line.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Tap select, saturating at the deepest entry.
  always_comb begin
    taps_s[0] = d_i;
    for (int i = 1; i <= DEPTH; i++) taps_s[i] = stage_q[i-1];
    if (tap_i > TW'(DEPTH)) sel_s = TW'(DEPTH);
    else sel_s = tap_i;
  end

  assign q_o = taps_s[sel_s];

endmodule

// File: rtl/ram_delay_pipe.sv
// Memory-latency injector: delays client requests towards a synchronous RAM and
// its read responses back to the client by runtime-configurable cycle counts.
module ram_delay_pipe
  import ram_delay_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_DELAY   = 8,
  parameter int MEM_LATENCY = 1,
  localparam int DW = $clog2(MAX_DELAY + 1),
  localparam int BW = DATA_WIDTH / 8,
  localparam int IW = $clog2(2 * MAX_DELAY + MEM_LATENCY + 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DW-1:0]         cfg_req_delay,
  input  logic [DW-1:0]         cfg_rsp_delay,
  input  logic                  cfg_pipelined,
  output logic                  cfg_pending,
  input  logic                  client_en,
  input  logic                  client_we,
  input  logic [ADDR_WIDTH-1:0] client_addr,
  input  logic [DATA_WIDTH-1:0] client_data_w,
  input  logic [BW-1:0]         client_be,
  output logic [DATA_WIDTH-1:0] client_data_r,
  output logic                  client_valid_r,
  output logic                  client_delay,
  output logic                  err_drop,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  output logic [BW-1:0]         mem_be,
  input  logic [DATA_WIDTH-1:0] mem_data_r,
  output logic [IW-1:0]         inflight
);

  localparam int PW = 2 + ADDR_WIDTH + DATA_WIDTH + BW;
  localparam int RW = 1 + DATA_WIDTH;

  logic [DW-1:0] req_delay_q, rsp_delay_q, req_delay_s, rsp_delay_s;
  Ram_delay_mode mode_q, mode_s;
  logic          accept_s, drop_s, apply_s, flush_s;
  logic          wr_done_s, rd_done_s, rd_issue_s, rd_tag_s;
  logic [PW-1:0] req_pkt_d, req_pkt_q, mem_pkt_s;
  logic [RW-1:0] rsp_pkt_s;
  logic [IW-1:0] inflight_d, inflight_q;
  logic          err_drop_d, err_drop_q;
  logic          cfg_pending_d, cfg_pending_q;

  assign req_delay_s = DW'(sat_delay(32'(cfg_req_delay), 32'(MAX_DELAY)));
  assign rsp_delay_s = DW'(sat_delay(32'(cfg_rsp_delay), 32'(MAX_DELAY)));
  assign mode_s      = cfg_pipelined ? MODE_PIPELINED : MODE_BLOCKING;

  // The completion cycle itself never stalls, so back-to-back requests fit.
  assign wr_done_s    = mem_en & mem_we;
  assign rd_done_s    = client_valid_r;
  assign client_delay = (mode_q == MODE_BLOCKING) && (inflight_q != '0) && !(wr_done_s || rd_done_s);
  assign accept_s     = client_en & ~client_delay;
  assign drop_s       = client_en & client_delay;
  assign apply_s      = (inflight_q == '0) && !accept_s;
  // Stale copies sit beyond the current taps; clear them so a new tap cannot expose them.
  assign flush_s      = reset | apply_s;

  // Next-state for the request stage, occupancy, drop flag and pending flag.
  always_comb begin
    req_pkt_d     = '0;
    inflight_d    = inflight_q + IW'(accept_s) - IW'(wr_done_s) - IW'(rd_done_s);
    err_drop_d    = err_drop_q | drop_s;
    cfg_pending_d = 1'b0;
    if (accept_s) req_pkt_d = {1'b1, client_we, client_addr, client_data_w, client_be};
    else req_pkt_d = '0;
    if (apply_s) cfg_pending_d = 1'b0;
    else cfg_pending_d = (req_delay_s != req_delay_q) || (rsp_delay_s != rsp_delay_q) || (mode_s != mode_q);
  end

  // Active configuration and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_delay_q   <= '0;
      rsp_delay_q   <= '0;
      mode_q        <= MODE_BLOCKING;
      req_pkt_q     <= '0;
      inflight_q    <= '0;
      err_drop_q    <= 1'b0;
      cfg_pending_q <= 1'b0;
    end else begin
      if (apply_s) begin
        req_delay_q <= req_delay_s;
        rsp_delay_q <= rsp_delay_s;
        mode_q      <= mode_s;
      end
      req_pkt_q     <= req_pkt_d;
      inflight_q    <= inflight_d;
      err_drop_q    <= err_drop_d;
      cfg_pending_q <= cfg_pending_d;
    end
  end

  ram_delay_tapline #(.WIDTH(PW), .DEPTH(MAX_DELAY)) u_req_line (
    .clk   (clk),
    .reset (flush_s),
    .tap_i (req_delay_q),
    .d_i   (req_pkt_q),
    .q_o   (mem_pkt_s)
  );

  assign {mem_en, mem_we, mem_addr, mem_data_w, mem_be} = mem_pkt_s;
  assign rd_issue_s = mem_en & ~mem_we;

  generate
    if (MEM_LATENCY == 0) begin : g_tag_comb
      assign rd_tag_s = rd_issue_s;
    end else begin : g_tag_pipe
      logic [MEM_LATENCY-1:0] tag_q;
      // Read flag travels alongside the RAM access to mark valid mem_data_r samples.
      always_ff @(posedge clk) begin
        if (reset) begin
          tag_q <= '0;
        end else begin
          tag_q[0] <= rd_issue_s;
          for (int i = 1; i < MEM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
      end
      assign rd_tag_s = tag_q[MEM_LATENCY-1];
    end
  endgenerate

  ram_delay_tapline #(.WIDTH(RW), .DEPTH(MAX_DELAY)) u_rsp_line (
    .clk   (clk),
    .reset (flush_s),
    .tap_i (rsp_delay_q),
    .d_i   ({rd_tag_s, mem_data_r}),
    .q_o   (rsp_pkt_s)
  );

  assign client_valid_r = rsp_pkt_s[DATA_WIDTH];
  assign client_data_r  = client_valid_r ? rsp_pkt_s[DATA_WIDTH-1:0] : '0;
  assign inflight       = inflight_q;
  assign err_drop       = err_drop_q;
  assign cfg_pending    = cfg_pending_q;

endmodule
